// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline definitions: payload field widths, per-stage packing
// offsets and default perf-counter width.
package cpu_pipe_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned STALL_CNT_W = 16;

  // MEM/WB payload: {wb_en, rd, result}
  localparam int unsigned MEMWB_RESULT_LSB = 0;
  localparam int unsigned MEMWB_RD_LSB     = MEMWB_RESULT_LSB + XLEN;
  localparam int unsigned MEMWB_WBEN_LSB   = MEMWB_RD_LSB + REG_ADDR_W;
  localparam int unsigned MEMWB_W          = MEMWB_WBEN_LSB + 1;

  // EX/MEM payload: {ctrl[3:0], rd, store_data, alu_result}
  localparam int unsigned EXMEM_ALU_LSB  = 0;
  localparam int unsigned EXMEM_STD_LSB  = EXMEM_ALU_LSB + XLEN;
  localparam int unsigned EXMEM_RD_LSB   = EXMEM_STD_LSB + XLEN;
  localparam int unsigned EXMEM_CTRL_LSB = EXMEM_RD_LSB + REG_ADDR_W;
  localparam int unsigned EXMEM_W        = EXMEM_CTRL_LSB + 4;

  function automatic logic [MEMWB_W-1:0] pack_memwb(input logic [XLEN-1:0]       result,
                                                    input logic [REG_ADDR_W-1:0] rd,
                                                    input logic                  wb_en);
    return {wb_en, rd, result};
  endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready payload channel between pipeline stages.
interface pipe_stage_buf_if #(
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset; sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_buf.sv
// One-stage pipeline register with valid/ready on both sides, a skid entry for
// full throughput under backpressure, flush/hold control and a stall counter.
module pipe_stage_buf
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = XLEN,
  parameter bit          CLEAR_DATA = 1'b1,
  parameter int unsigned CNT_W      = STALL_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             hold_i,
  pipe_stage_buf_if.slave  in_if,
  pipe_stage_buf_if.master out_if,
  output logic [CNT_W-1:0] stall_cnt
);

  logic              r_main_v, r_skid_v;
  logic [DATA_W-1:0] r_main_d, r_skid_d;
  logic              w_main_v_nxt, w_skid_v_nxt;
  logic [DATA_W-1:0] w_main_d_nxt, w_skid_d_nxt;
  logic              w_in_ready, w_out_valid, w_accept, w_emit, w_stall;

  assign w_in_ready  = !r_skid_v && !hold_i && !flush_i;
  assign w_out_valid = r_main_v && !hold_i && !flush_i;
  assign w_accept    = in_if.valid && w_in_ready;
  assign w_emit      = w_out_valid && out_if.ready;

  assign in_if.ready  = w_in_ready;
  assign out_if.valid = w_out_valid;
  assign out_if.data  = r_main_d;

  always_comb begin
    w_main_v_nxt = r_main_v;
    w_skid_v_nxt = r_skid_v;
    w_main_d_nxt = r_main_d;
    w_skid_d_nxt = r_skid_d;
    if (flush_i) begin
      w_main_v_nxt = 1'b0;
      w_skid_v_nxt = 1'b0;
      if (CLEAR_DATA) begin
        w_main_d_nxt = '0;
        w_skid_d_nxt = '0;
      end
    end else if (!hold_i) begin
      if (!r_main_v) begin
        if (w_accept) begin
          w_main_v_nxt = 1'b1;
          w_main_d_nxt = in_if.data;
        end
      end else if (w_emit) begin
        // Skid drains first so older data never gets overtaken.
        if (r_skid_v) begin
          w_main_d_nxt = r_skid_d;
          w_skid_v_nxt = 1'b0;
        end else if (w_accept) begin
          w_main_d_nxt = in_if.data;
        end else begin
          w_main_v_nxt = 1'b0;
        end
      end else if (w_accept) begin
        w_skid_v_nxt = 1'b1;
        w_skid_d_nxt = in_if.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else begin
      r_main_v <= w_main_v_nxt;
      r_skid_v <= w_skid_v_nxt;
    end
  end

  if (CLEAR_DATA) begin : g_data_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_main_d <= '0;
        r_skid_d <= '0;
      end else begin
        r_main_d <= w_main_d_nxt;
        r_skid_d <= w_skid_d_nxt;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk) begin
      r_main_d <= w_main_d_nxt;
      r_skid_d <= w_skid_d_nxt;
    end
  end

  assign w_stall = (r_main_v && !out_if.ready && !flush_i) || hold_i;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_stall),
    .o_cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: stimulus pushes expected payloads into a
// queue, an independent monitor pops and compares on every downstream transfer.
module tb_pipe_stage_buf;
  import cpu_pipe_pkg::*;

  localparam int unsigned DW = XLEN;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic          flush_i;
  logic          hold_i;
  logic [CW-1:0] stall_cnt;

  pipe_stage_buf_if #(.DATA_W(DW)) up_if ();
  pipe_stage_buf_if #(.DATA_W(DW)) dn_if ();

  pipe_stage_buf #(
    .DATA_W     (DW),
    .CLEAR_DATA (1'b1),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush_i),
    .hold_i    (hold_i),
    .in_if     (up_if),
    .out_if    (dn_if),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [DW-1:0] d);
    up_if.valid = 1'b1;
    up_if.data  = d;
  endtask

  // Monitor: every downstream transfer must match the oldest expected payload.
  always @(negedge clk) begin
    if (rst_n && dn_if.valid && dn_if.ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", dn_if.data, 32'hDEAD_BEEF);
      end else begin
        chk("out_data", dn_if.data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    up_if.valid = 1'b0; up_if.data = '0; dn_if.ready = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(dn_if.valid), 32'd0);
    chk("rst_in_ready",  32'(up_if.ready), 32'd1);
    chk("rst_out_data",  dn_if.data,       32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt),   32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Streaming at full throughput
    dn_if.ready = 1'b1;
    offer(32'h11); exp_q.push_back(32'h11);
    @(negedge clk); chk("stream_in_ready0", 32'(up_if.ready), 32'd1);
    step();
    offer(32'h22); exp_q.push_back(32'h22);
    @(negedge clk); chk("stream_in_ready1", 32'(up_if.ready), 32'd1);
    step();
    offer(32'h33); exp_q.push_back(32'h33);
    @(negedge clk); chk("stream_in_ready2", 32'(up_if.ready), 32'd1);
    step();
    up_if.valid = 1'b0;
    step(); step();
    chk("stream_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: A to main, B to skid, C refused until space frees
    dn_if.ready = 1'b0;
    offer(32'hA); exp_q.push_back(32'hA);
    step();
    offer(32'hB); exp_q.push_back(32'hB);
    step();
    offer(32'hC); exp_q.push_back(32'hC);
    @(negedge clk);
    chk("bp_in_ready_full", 32'(up_if.ready), 32'd0);
    chk("bp_stall_1",       32'(stall_cnt),   32'd1);
    step(); step();
    dn_if.ready = 1'b1;
    @(negedge clk);
    chk("bp_stall_3",   32'(stall_cnt), 32'd3);
    chk("bp_main_data", dn_if.data,     32'hA);
    step();
    step();
    up_if.valid = 1'b0;
    step(); step();
    chk("bp_stall_final", 32'(stall_cnt), 32'd3);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Hold for 4 cycles with a valid main entry
    offer(32'h55); exp_q.push_back(32'h55);
    step();
    up_if.valid = 1'b0;
    hold_i = 1'b1;
    @(negedge clk);
    chk("hold_out_valid", 32'(dn_if.valid), 32'd0);
    chk("hold_in_ready",  32'(up_if.ready), 32'd0);
    chk("hold_data_kept", dn_if.data,       32'h55);
    repeat (4) step();
    hold_i = 1'b0;
    @(negedge clk);
    chk("hold_stall_7", 32'(stall_cnt), 32'd7);
    step(); step();
    chk("hold_drained", 32'(exp_q.size()), 32'd0);

    // Flush with both entries full; the flush-cycle input is dropped
    dn_if.ready = 1'b0;
    offer(32'h71); step();
    offer(32'h72); step();
    offer(32'h73); flush_i = 1'b1;
    @(negedge clk);
    chk("flush_out_valid_now", 32'(dn_if.valid), 32'd0);
    step();
    flush_i = 1'b0; up_if.valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(dn_if.valid), 32'd0);
    chk("flush_in_ready",  32'(up_if.ready), 32'd1);
    chk("flush_out_data",  dn_if.data,       32'd0);
    chk("flush_stall_8",   32'(stall_cnt),   32'd8);

    // Flush and hold together: flush wins, hold still counts a stall
    step();
    offer(32'h81); step();
    offer(32'h82); flush_i = 1'b1; hold_i = 1'b1;
    step();
    flush_i = 1'b0; hold_i = 1'b0; up_if.valid = 1'b0;
    @(negedge clk);
    chk("fh_out_valid", 32'(dn_if.valid), 32'd0);
    chk("fh_in_ready",  32'(up_if.ready), 32'd1);
    chk("fh_out_data",  dn_if.data,       32'd0);
    chk("fh_stall_9",   32'(stall_cnt),   32'd9);
    step();
    dn_if.ready = 1'b1;
    repeat (3) step();

    // Saturation, then asynchronous reset in mid-cycle
    hold_i = 1'b1;
    repeat (20) step();
    chk("sat_stall_15", 32'(stall_cnt), 32'd15);
    step();
    chk("sat_stall_held", 32'(stall_cnt), 32'd15);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_stall", 32'(stall_cnt), 32'd0);
    hold_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
